debounce_edge: RTL
==================

# debounce_edge

Debounce-and-edge stage sitting directly downstream of the two-flop input synchronizer on each push-button/switch input of the counter design. Consumes the already-synchronized level, requires it to hold a new value for STABLE_CYCLES consecutive clocks before accepting it, and produces a clean level, one-cycle rise/fall pulses, and a wrapping press counter. The counter datapath consumes `rise` as its increment strobe.

## Interface
- STABLE_CYCLES, 4: consecutive differing samples required to accept a new level; legal range ≥1.
- TIMER_W, 3: stability timer width; must satisfy 2^TIMER_W > STABLE_CYCLES.
- CNT_W, 4: press counter width.

- clk  input  1  sole clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset; sampled on posedge clk.
- inp  input  1  synchronized raw input, already double-registered to clk upstream; no further synchronization here.
- level  output  1  debounced level, registered.
- rise  output  1  one-cycle pulse, registered, coincident with level 0→1.
- fall  output  1  one-cycle pulse, registered, coincident with level 1→0.
- count  output  CNT_W  number of accepted rises modulo 2^CNT_W, registered.

## Operation
- States: IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW. `level` = 1 in IDLE_HIGH and WAIT_LOW, else 0.
- IDLE_LOW: inp=0 → stay; inp=1 → WAIT_HIGH, timer=1 (or, if STABLE_CYCLES=1, go straight to IDLE_HIGH with rise).
- WAIT_HIGH: inp=0 → IDLE_LOW, timer=0, no pulse. inp=1 and timer=STABLE_CYCLES-1 → IDLE_HIGH, timer=0, rise=1, count+1. Otherwise timer+1.
- IDLE_HIGH / WAIT_LOW mirror the above with inp inverted; acceptance asserts fall; count unchanged.
- rise and fall never asserted in the same cycle; each deasserts the cycle after it is asserted.
- count wraps 2^CNT_W-1 → 0 with no flag; increments only on accepted rises.
- Timer never exceeds STABLE_CYCLES-1; no overflow path.
- Glitch rule: any single sample equal to the current level during WAIT_* aborts and fully restarts the stability window.

## Timing
- Reset (rst=1 at posedge): state IDLE_LOW, timer 0, level 0, rise 0, fall 0, count 0. Reset overrides all other activity, including mid-WAIT and the cycle an acceptance would occur (no pulse, no count increment).
- inp held 1 during and after reset: no immediate acceptance; needs STABLE_CYCLES samples after the first non-reset posedge.
- Latency: if inp is first sampled 1 at posedge E (state IDLE_LOW) and stays 1, level and rise are 1 after posedge E+STABLE_CYCLES-1; count updates on that same edge. Same for fall.
- End-to-end from pin: +2 cycles for the upstream synchronizer (not part of this block).
- No combinational path from inp to any output.

## Test plan
- Reset: drive inp=1, rst=1 for 3 cycles, release → level=0, rise=0, fall=0, count=0 after reset; level rises exactly 4 posedges after release (STABLE_CYCLES=4).
- Clean press: inp 0→1 first sampled at edge E, held 10 cycles → level=1 and rise=1 after E+3 only, rise=0 after E+4, count=1.
- Bounce: inp pattern 1,1,1,0,1,1,1,1 from IDLE_LOW → no pulse until four consecutive 1s; single rise, count=1; symmetric 0-glitch test during release produces single fall.
- Release: from IDLE_HIGH, inp→0 held 6 cycles → fall=1 for exactly one cycle 3 edges after first 0 sample, level=0, count unchanged.
- Wrap: 16 clean presses with CNT_W=4 → count goes 15 → 0 on 16th rise, 16 rise pulses total, no fall coincident with any rise.
- Reset mid-window: inp=1 for 3 samples (WAIT_HIGH, timer=3), rst=1 on 4th edge → no rise, count=0, level=0; after release, full 4-sample window required again. Also STABLE_CYCLES=1 build: rise follows first 1 sample on same edge.

Source files
------------

// File: rtl/debounce_edge.sv
// Debounce stage for an already-synchronized button/switch level.
// Outputs a clean level, one-cycle rise/fall pulses and a wrapping press counter.
module debounce_edge #(
    parameter int STABLE_CYCLES = 4,
    parameter int TIMER_W       = 3,
    parameter int CNT_W         = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inp,
    output logic             level,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] count,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    localparam logic [TIMER_W-1:0] LP_ONE  = TIMER_W'(1);
    localparam logic [TIMER_W-1:0] LP_LAST = TIMER_W'(STABLE_CYCLES - 1);

    // Handshake: none; inp is a free-running level, outputs are registered strobes/levels.
    state_t             r_state;
    logic [TIMER_W-1:0] r_timer;
    logic               r_level;
    logic               r_rise;
    logic               r_fall;
    logic [CNT_W-1:0]   r_count;

    state_t             w_state_nxt;
    logic [TIMER_W-1:0] w_timer_nxt;
    logic               w_rise_nxt;
    logic               w_fall_nxt;

    // r_timer holds the number of consecutive new-level samples already seen.
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        case (r_state)
            IDLE_LOW: begin
                if (inp) begin
                    if (STABLE_CYCLES == 1) begin
                        w_state_nxt = IDLE_HIGH;
                        w_timer_nxt = '0;
                        w_rise_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = WAIT_HIGH;
                        w_timer_nxt = LP_ONE;
                    end
                end
            end
            WAIT_HIGH: begin
                if (!inp) begin
                    w_state_nxt = IDLE_LOW;
                    w_timer_nxt = '0;
                end else if (r_timer == LP_LAST) begin
                    w_state_nxt = IDLE_HIGH;
                    w_timer_nxt = '0;
                    w_rise_nxt  = 1'b1;
                end else begin
                    w_timer_nxt = r_timer + LP_ONE;
                end
            end
            IDLE_HIGH: begin
                if (!inp) begin
                    if (STABLE_CYCLES == 1) begin
                        w_state_nxt = IDLE_LOW;
                        w_timer_nxt = '0;
                        w_fall_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = WAIT_LOW;
                        w_timer_nxt = LP_ONE;
                    end
                end
            end
            WAIT_LOW: begin
                if (inp) begin
                    w_state_nxt = IDLE_HIGH;
                    w_timer_nxt = '0;
                end else if (r_timer == LP_LAST) begin
                    w_state_nxt = IDLE_LOW;
                    w_timer_nxt = '0;
                    w_fall_nxt  = 1'b1;
                end else begin
                    w_timer_nxt = r_timer + LP_ONE;
                end
            end
            default: begin
                w_state_nxt = IDLE_LOW;
                w_timer_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE_LOW;
            r_timer <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_level <= (w_state_nxt == IDLE_HIGH) || (w_state_nxt == WAIT_LOW);
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
            if (w_rise_nxt) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign level     = r_level;
    assign rise      = r_rise;
    assign fall      = r_fall;
    assign count     = r_count;
    assign dbg_state = r_state;

endmodule
